// File: rtl/eight_bit_serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// Width, counter width and FSM state encoding.
package eight_bit_serial_subtractor_pkg;

    localparam int SUB_WIDTH = 8;
    localparam int SUB_CNT_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } sub_state_t;

endpackage

// File: rtl/eight_bit_serial_subtractor_fs.sv
// Single-bit full subtractor cell: d = a - b - bin.
// Purely combinational; borrow is registered by the caller.
module one_bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of one bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial 8-bit subtractor, LSB first, one bit per clock.
// Optional signed overflow flag: define SERIAL_SUB_OVERFLOW_EN.
module eight_bit_serial_subtractor
    import eight_bit_serial_subtractor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SUB_WIDTH-1:0] a,
    input  logic [SUB_WIDTH-1:0] b,
    input  logic                 bin,
    output logic [SUB_WIDTH-1:0] diff,
    output logic                 bout,
    output logic                 busy,
    output logic                 done
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic                 ovf
`endif
);

    localparam logic [SUB_CNT_W-1:0] CNT_LAST =
        SUB_CNT_W'(SUB_WIDTH - 1);

    sub_state_t           state_q;
    logic [SUB_WIDTH-1:0] a_q;
    logic [SUB_WIDTH-1:0] b_q;
    logic [SUB_WIDTH-1:0] res_q;
    logic [SUB_CNT_W-1:0] cnt_q;
    logic                 br_q;
    logic [SUB_WIDTH-1:0] diff_q;
    logic                 bout_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 d_bit;
    logic                 br_d;
    logic [SUB_WIDTH-1:0] res_d;

    one_bit_full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (br_d)
    );

    // Result register with the new bit entering at the MSB
    always_comb begin
        res_d = {d_bit, res_q[SUB_WIDTH-1:1]};
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic sign_diff_q;
    logic a_msb_q;
    logic ovf_q;

    // Operand sign capture and overflow flag, updated with diff
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_diff_q <= 1'b0;
            a_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                sign_diff_q <= a[SUB_WIDTH-1] ^ b[SUB_WIDTH-1];
                a_msb_q     <= a[SUB_WIDTH-1];
            end
            if (state_q == S_SHIFT && cnt_q == CNT_LAST) begin
                ovf_q <= sign_diff_q & (d_bit ^ a_msb_q);
            end
        end
    end

    assign ovf = ovf_q;
`endif

    // FSM, operand shifters, counter, borrow and output registers;
    // busy/done are registered one cycle behind the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_q == S_SHIFT);
            done_q <= (state_q == S_DONE);
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    res_q <= res_d;
                    br_q  <= br_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + SUB_CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
